vga_mem_responder: RTL and testbench

Memory-side responder for the display pixel fetch handshake. It accepts one-cycle `vga_flag` requests carrying a pixel coordinate and issues a ZBT SRAM read for the 36-bit word that holds that pixel pair. It returns the word on `vga_pixel` with a one-cycle `done_vga` pulse. It also interleaves lower-priority frame-buffer writes from the capture path and owns the display/write bank selection.

---
 rtl/vga_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_vga_mem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_responder.sv
// vga_mem_responder: ZBT SRAM front end for the display pixel fetch.
// Serves one-cycle display read requests with a fixed-latency response and
// slots lower-priority capture writes into idle SRAM cycles.
// Optional feature macro: DOUBLE_BUFFER_EN enables display/write bank swapping;
// without it everything lives in bank 0.
module vga_mem_responder #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_flag,
    input  logic        vga_flag,
    input  logic [9:0]  vga_hcount,
    input  logic [9:0]  vga_vcount,
    output logic [35:0] vga_pixel,
    output logic        done_vga,
    input  logic        wr_flag,
    input  logic [17:0] wr_addr,
    input  logic [35:0] wr_data,
    output logic        wr_ready,
    output logic [18:0] mem_addr,
    output logic        mem_we_b,
    output logic [35:0] mem_data_out,
    output logic        mem_data_oe,
    input  logic [35:0] mem_data_in,
    output logic        display_bank
);

    localparam int DATA_W = 36;

    // Word offset of a pixel pair: v*320 + h/2, built from shifts.
    function automatic logic [17:0] pix_offset(input logic [8:0] h_pair, input logic [9:0] v);
        logic [17:0] v18;
        v18 = {8'b0, v};
        return (v18 << 8) + (v18 << 6) + {9'b0, h_pair};
    endfunction

    logic              in_range;
    logic [17:0]       rd_offset;
    logic              swap_now;
    logic              bank_eff;
    logic              wr_bank;
    logic              wr_accept;
    logic              wr_issue;

    logic              pend_bank;
    logic [17:0]       pend_addr;
    logic [DATA_W-1:0] pend_data;

    logic [MEM_LATENCY:0]   rd_vld_p;
    logic [MEM_LATENCY:0]   rd_ok_p;
    logic [MEM_LATENCY-1:0] wr_vld_p;
    logic [DATA_W-1:0]      wr_data_p [MEM_LATENCY];

`ifdef DOUBLE_BUFFER_EN
    logic swap_pending;

    // A completed write frame arms a swap that lands on the next frame-start request;
    // a frame_flag arriving with that request re-arms for the following frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            display_bank <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (swap_now)
                display_bank <= ~display_bank;
            if (frame_flag)
                swap_pending <= 1'b1;
            else if (swap_now)
                swap_pending <= 1'b0;
        end
    end
`else
    logic unused_frame_flag;
    assign unused_frame_flag = frame_flag;
    assign display_bank      = 1'b0;
`endif

    // Request decode: range check, address, bank selection and SRAM slot arbitration.
    always_comb begin
        in_range  = (vga_hcount < 10'd640) && (vga_vcount < 10'd480);
        rd_offset = pix_offset(vga_hcount[9:1], vga_vcount);
`ifdef DOUBLE_BUFFER_EN
        swap_now  = vga_flag && swap_pending && (vga_hcount == 10'd0) && (vga_vcount == 10'd0);
        bank_eff  = display_bank ^ swap_now;
        wr_bank   = ~bank_eff;
`else
        swap_now  = 1'b0;
        bank_eff  = 1'b0;
        wr_bank   = 1'b0;
`endif
        wr_accept = wr_flag && wr_ready;
        wr_issue  = !vga_flag && !wr_ready;
    end

    // Stage p0: SRAM address/command issue, pending-write slot and pipeline valids.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_addr <= 19'd0;
            mem_we_b <= 1'b1;
            wr_ready <= 1'b1;
            rd_vld_p <= '0;
            wr_vld_p <= '0;
        end else begin
            mem_we_b <= 1'b1;
            if (vga_flag) begin
                if (in_range)
                    mem_addr <= {bank_eff, rd_offset};
            end else if (wr_issue) begin
                mem_addr <= {pend_bank, pend_addr};
                mem_we_b <= 1'b0;
            end

            if (wr_accept)
                wr_ready <= 1'b0;
            else if (wr_issue)
                wr_ready <= 1'b1;

            rd_vld_p[0] <= vga_flag;
            for (int k = 1; k <= MEM_LATENCY; k++)
                rd_vld_p[k] <= rd_vld_p[k-1];

            wr_vld_p[0] <= wr_issue;
            for (int k = 1; k < MEM_LATENCY; k++)
                wr_vld_p[k] <= wr_vld_p[k-1];
        end
    end

    // Data-side registers: pending write contents and the payloads riding the valid pipes.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            pend_bank <= wr_bank;
            pend_addr <= wr_addr;
            pend_data <= wr_data;
        end
        rd_ok_p[0] <= in_range;
        for (int k = 1; k <= MEM_LATENCY; k++)
            rd_ok_p[k] <= rd_ok_p[k-1];
        wr_data_p[0] <= pend_data;
        for (int k = 1; k < MEM_LATENCY; k++)
            wr_data_p[k] <= wr_data_p[k-1];
    end

    // Stage p(L+1): capture read data (zero for out-of-range) and pulse done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_vga  <= 1'b0;
            vga_pixel <= '0;
        end else begin
            done_vga <= rd_vld_p[MEM_LATENCY];
            if (rd_vld_p[MEM_LATENCY])
                vga_pixel <= rd_ok_p[MEM_LATENCY] ? mem_data_in : '0;
        end
    end

    // Stage p(L): drive ZBT write data MEM_LATENCY cycles after the write command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_data_oe  <= 1'b0;
            mem_data_out <= '0;
        end else begin
            mem_data_oe <= wr_vld_p[MEM_LATENCY-1];
            if (wr_vld_p[MEM_LATENCY-1])
                mem_data_out <= wr_data_p[MEM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_vga_mem_responder.sv
// Directed bench for vga_mem_responder with a 2-cycle pipelined ZBT SRAM model.
module tb_vga_mem_responder;

`ifdef DOUBLE_BUFFER_EN
    localparam logic DB = 1'b1;
`else
    localparam logic DB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_flag = 1'b0;
    logic        vga_flag = 1'b0;
    logic [9:0]  vga_hcount = '0;
    logic [9:0]  vga_vcount = '0;
    logic [35:0] vga_pixel;
    logic        done_vga;
    logic        wr_flag = 1'b0;
    logic [17:0] wr_addr = '0;
    logic [35:0] wr_data = '0;
    logic        wr_ready;
    logic [18:0] mem_addr;
    logic        mem_we_b;
    logic [35:0] mem_data_out;
    logic        mem_data_oe;
    logic [35:0] mem_data_in = '0;
    logic        display_bank;

    int n_vec = 0;
    int n_err = 0;

    vga_mem_responder #(.MEM_LATENCY(2)) dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag),
        .vga_flag(vga_flag), .vga_hcount(vga_hcount), .vga_vcount(vga_vcount),
        .vga_pixel(vga_pixel), .done_vga(done_vga),
        .wr_flag(wr_flag), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_addr(mem_addr), .mem_we_b(mem_we_b), .mem_data_out(mem_data_out),
        .mem_data_oe(mem_data_oe), .mem_data_in(mem_data_in), .display_bank(display_bank)
    );

    always #5 clock = ~clock;

    // SRAM contents as a function of address.
    function automatic logic [35:0] sram_word(input logic [18:0] a);
        return (a == 19'h00282) ? 36'h123456789 : {a, 17'h15A5A};
    endfunction

    // Pipelined ZBT read: address sampled one edge after issue, data valid after the next.
    logic [18:0] sram_a1 = '0;
    logic        sram_rd1 = 1'b0;
    always @(posedge clock) begin
        sram_a1     <= mem_addr;
        sram_rd1    <= mem_we_b;
        mem_data_in <= sram_rd1 ? sram_word(sram_a1) : 36'h0;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle(2);
        n_vec++; if (vga_pixel !== 36'h0) begin n_err++; $display("FAIL rst_pixel: got %h want %h", vga_pixel, 36'h0); end
        n_vec++; if (done_vga !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_vga); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
        n_vec++; if (mem_addr !== 19'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL rst_we_b: got %b want 1", mem_we_b); end
        n_vec++; if (mem_data_out !== 36'h0) begin n_err++; $display("FAIL rst_data_out: got %h want 0", mem_data_out); end
        n_vec++; if (mem_data_oe !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b want 0", mem_data_oe); end
        n_vec++; if (display_bank !== 1'b0) begin n_err++; $display("FAIL rst_bank: got %b want 0", display_bank); end
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_read;
        vga_hcount = 10'd5; vga_vcount = 10'd2; vga_flag = 1'b1;
        tick;
        vga_flag = 1'b0;
        n_vec++; if (mem_addr !== 19'h00282) begin n_err++; $display("FAIL rd_addr: got %h want %h", mem_addr, 19'h00282); end
        n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL rd_we_b: got %b want 1", mem_we_b); end
        n_vec++; if (done_vga !== 1'b0) begin n_err++; $display("FAIL rd_done_e0: got %b want 0", done_vga); end
        tick;
        n_vec++; if (done_vga !== 1'b0) begin n_err++; $display("FAIL rd_done_e1: got %b want 0", done_vga); end
        tick;
        n_vec++; if (done_vga !== 1'b0) begin n_err++; $display("FAIL rd_done_e2: got %b want 0", done_vga); end
        tick;
        n_vec++; if (done_vga !== 1'b1) begin n_err++; $display("FAIL rd_done_e3: got %b want 1", done_vga); end
        n_vec++; if (vga_pixel !== 36'h123456789) begin n_err++; $display("FAIL rd_pixel: got %h want %h", vga_pixel, 36'h123456789); end
        tick;
        n_vec++; if (done_vga !== 1'b0) begin n_err++; $display("FAIL rd_done_e4: got %b want 0", done_vga); end
    endtask

    task automatic test_out_of_range;
        vga_hcount = 10'd700; vga_vcount = 10'd10; vga_flag = 1'b1;
        tick;
        vga_flag = 1'b0;
        n_vec++; if (mem_addr !== 19'h00282) begin n_err++; $display("FAIL oor_addr: got %h want %h", mem_addr, 19'h00282); end
        n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL oor_we_b: got %b want 1", mem_we_b); end
        idle(2);
        tick;
        n_vec++; if (done_vga !== 1'b1) begin n_err++; $display("FAIL oor_done: got %b want 1", done_vga); end
        n_vec++; if (vga_pixel !== 36'h0) begin n_err++; $display("FAIL oor_pixel: got %h want 0", vga_pixel); end
        tick;
        // first row out of range
        vga_hcount = 10'd0; vga_vcount = 10'd480; vga_flag = 1'b1;
        tick;
        vga_flag = 1'b0;
        n_vec++; if (mem_addr !== 19'h00282) begin n_err++; $display("FAIL oor_v480_addr: got %h want %h", mem_addr, 19'h00282); end
        idle(2);
        tick;
        n_vec++; if (done_vga !== 1'b1) begin n_err++; $display("FAIL oor_v480_done: got %b want 1", done_vga); end
        tick;
        // last in-range pixel: 479*320 + 319 = 153599
        vga_hcount = 10'd639; vga_vcount = 10'd479; vga_flag = 1'b1;
        tick;
        vga_flag = 1'b0;
        n_vec++; if (mem_addr !== 19'h257FF) begin n_err++; $display("FAIL edge_addr: got %h want %h", mem_addr, 19'h257FF); end
        idle(2);
        tick;
        n_vec++; if (done_vga !== 1'b1) begin n_err++; $display("FAIL edge_done: got %b want 1", done_vga); end
        n_vec++; if (vga_pixel !== sram_word(19'h257FF)) begin n_err++; $display("FAIL edge_pixel: got %h want %h", vga_pixel, sram_word(19'h257FF)); end
        tick;
    endtask

    task automatic test_collision;
        logic [18:0] exp_wa;
        exp_wa = {DB, 18'h00010};
        vga_hcount = 10'd5; vga_vcount = 10'd2; vga_flag = 1'b1;
        wr_flag = 1'b1; wr_addr = 18'h00010; wr_data = 36'hABC;
        tick;
        vga_flag = 1'b0; wr_flag = 1'b0;
        n_vec++; if (mem_addr !== 19'h00282) begin n_err++; $display("FAIL col_rd_addr: got %h want %h", mem_addr, 19'h00282); end
        n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL col_rd_we_b: got %b want 1", mem_we_b); end
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL col_wr_ready_lo: got %b want 0", wr_ready); end
        tick;
        n_vec++; if (mem_addr !== exp_wa) begin n_err++; $display("FAIL col_wr_addr: got %h want %h", mem_addr, exp_wa); end
        n_vec++; if (mem_we_b !== 1'b0) begin n_err++; $display("FAIL col_wr_we_b: got %b want 0", mem_we_b); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL col_wr_ready_hi: got %b want 1", wr_ready); end
        tick;
        n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL col_we_b_release: got %b want 1", mem_we_b); end
        n_vec++; if (mem_data_oe !== 1'b0) begin n_err++; $display("FAIL col_oe_early: got %b want 0", mem_data_oe); end
        tick;
        n_vec++; if (mem_data_oe !== 1'b1) begin n_err++; $display("FAIL col_oe: got %b want 1", mem_data_oe); end
        n_vec++; if (mem_data_out !== 36'hABC) begin n_err++; $display("FAIL col_data_out: got %h want %h", mem_data_out, 36'hABC); end
        n_vec++; if (done_vga !== 1'b1) begin n_err++; $display("FAIL col_done: got %b want 1", done_vga); end
        n_vec++; if (vga_pixel !== 36'h123456789) begin n_err++; $display("FAIL col_pixel: got %h want %h", vga_pixel, 36'h123456789); end
        tick;
        n_vec++; if (mem_data_oe !== 1'b0) begin n_err++; $display("FAIL col_oe_drop: got %b want 0", mem_data_oe); end
        idle(1);
    endtask

    task automatic test_back_to_back;
        logic [18:0] exp_wa;
        exp_wa = {DB, 18'h00020};
        wr_flag = 1'b1; wr_addr = 18'h00020; wr_data = 36'h5;
        tick;
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_lo: got %b want 0", wr_ready); end
        n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL b2b_no_same_edge: got %b want 1", mem_we_b); end
        // read wins the slot; the second write arrives while busy and must be dropped
        vga_hcount = 10'd2; vga_vcount = 10'd0; vga_flag = 1'b1;
        wr_addr = 18'h00030; wr_data = 36'h9;
        tick;
        vga_flag = 1'b0; wr_flag = 1'b0;
        n_vec++; if (mem_addr !== 19'h00001) begin n_err++; $display("FAIL b2b_rd_addr: got %h want %h", mem_addr, 19'h00001); end
        n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL b2b_rd_we_b: got %b want 1", mem_we_b); end
        tick;
        n_vec++; if (mem_addr !== exp_wa) begin n_err++; $display("FAIL b2b_wr_addr: got %h want %h", mem_addr, exp_wa); end
        n_vec++; if (mem_we_b !== 1'b0) begin n_err++; $display("FAIL b2b_wr_we_b: got %b want 0", mem_we_b); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_hi: got %b want 1", wr_ready); end
        tick;
        tick;
        n_vec++; if (done_vga !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", done_vga); end
        n_vec++; if (vga_pixel !== sram_word(19'h00001)) begin n_err++; $display("FAIL b2b_pixel: got %h want %h", vga_pixel, sram_word(19'h00001)); end
        n_vec++; if (mem_data_oe !== 1'b1) begin n_err++; $display("FAIL b2b_oe: got %b want 1", mem_data_oe); end
        n_vec++; if (mem_data_out !== 36'h5) begin n_err++; $display("FAIL b2b_data_out: got %h want %h", mem_data_out, 36'h5); end
        tick;
        n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL b2b_ignored_we_b: got %b want 1", mem_we_b); end
        n_vec++; if (mem_addr !== exp_wa) begin n_err++; $display("FAIL b2b_ignored_addr: got %h want %h", mem_addr, exp_wa); end
        n_vec++; if (mem_data_oe !== 1'b0) begin n_err++; $display("FAIL b2b_ignored_oe: got %b want 0", mem_data_oe); end
        idle(2);
    endtask

    task automatic test_swap;
        frame_flag = 1'b1;
        tick;
        frame_flag = 1'b0;
        vga_hcount = 10'd0; vga_vcount = 10'd0; vga_flag = 1'b1;
        tick;
        vga_flag = 1'b0;
        n_vec++; if (display_bank !== DB) begin n_err++; $display("FAIL swp_bank1: got %b want %b", display_bank, DB); end
        n_vec++; if (mem_addr !== {DB, 18'h0}) begin n_err++; $display("FAIL swp_rd_addr: got %h want %h", mem_addr, {DB, 18'h0}); end
        wr_flag = 1'b1; wr_addr = 18'h00040; wr_data = 36'h77;
        tick;
        wr_flag = 1'b0;
        tick;
        n_vec++; if (mem_addr !== 19'h00040) begin n_err++; $display("FAIL swp_wr_addr: got %h want %h", mem_addr, 19'h00040); end
        n_vec++; if (mem_we_b !== 1'b0) begin n_err++; $display("FAIL swp_wr_we_b: got %b want 0", mem_we_b); end
        // frame_flag coincident with a frame start is deferred to the next frame start
        frame_flag = 1'b1; vga_flag = 1'b1;
        tick;
        frame_flag = 1'b0;
        n_vec++; if (display_bank !== DB) begin n_err++; $display("FAIL swp_defer_bank: got %b want %b", display_bank, DB); end
        tick;
        vga_flag = 1'b0;
        n_vec++; if (display_bank !== 1'b0) begin n_err++; $display("FAIL swp_bank0: got %b want 0", display_bank); end
        n_vec++; if (mem_addr !== 19'h0) begin n_err++; $display("FAIL swp_rd_addr0: got %h want 0", mem_addr); end
        wr_flag = 1'b1; wr_addr = 18'h00050; wr_data = 36'h88;
        tick;
        wr_flag = 1'b0;
        tick;
        n_vec++; if (mem_addr !== {DB, 18'h00050}) begin n_err++; $display("FAIL swp_wr_addr2: got %h want %h", mem_addr, {DB, 18'h00050}); end
        vga_flag = 1'b1;
        tick;
        vga_flag = 1'b0;
        n_vec++; if (display_bank !== 1'b0) begin n_err++; $display("FAIL swp_no_rearm: got %b want 0", display_bank); end
        idle(5);
    endtask

    task automatic test_reset_mid;
        vga_hcount = 10'd5; vga_vcount = 10'd2; vga_flag = 1'b1;
        wr_flag = 1'b1; wr_addr = 18'h00060; wr_data = 36'h66;
        tick;
        vga_flag = 1'b0; wr_flag = 1'b0;
        reset = 1'b0;
        #1;
        n_vec++; if (vga_pixel !== 36'h0) begin n_err++; $display("FAIL rm_pixel: got %h want 0", vga_pixel); end
        n_vec++; if (done_vga !== 1'b0) begin n_err++; $display("FAIL rm_done: got %b want 0", done_vga); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rm_wr_ready: got %b want 1", wr_ready); end
        n_vec++; if (mem_addr !== 19'h0) begin n_err++; $display("FAIL rm_addr: got %h want 0", mem_addr); end
        n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL rm_we_b: got %b want 1", mem_we_b); end
        n_vec++; if (mem_data_oe !== 1'b0) begin n_err++; $display("FAIL rm_oe: got %b want 0", mem_data_oe); end
        n_vec++; if (mem_data_out !== 36'h0) begin n_err++; $display("FAIL rm_data_out: got %h want 0", mem_data_out); end
        n_vec++; if (display_bank !== 1'b0) begin n_err++; $display("FAIL rm_bank: got %b want 0", display_bank); end
        tick;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_vec++; if (done_vga !== 1'b0) begin n_err++; $display("FAIL rm_no_done[%0d]: got %b want 0", i, done_vga); end
            n_vec++; if (mem_we_b !== 1'b1) begin n_err++; $display("FAIL rm_no_write[%0d]: got %b want 1", i, mem_we_b); end
        end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready_after: got %b want 1", wr_ready); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_out_of_range;
        test_collision;
        test_back_to_back;
        test_swap;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
